// File: rtl/ecc_result_tx.sv
// Snapshots each newly valid ECC result point (mP / mnP) and streams it to the host
// as a byte frame: header, X (MSB byte first), Y (MSB byte first), valid/ready handshake.
//
// state | meaning
// IDLE  | no frame; waiting for a new mP/mnP result
// HDR   | presenting the header byte
// XMIT  | presenting coordinate bytes from the shift register
module ecc_result_tx #(
    parameter int          MAX_BITS = 256,
    parameter logic [7:0]  HDR_MP   = 8'hA1,
    parameter logic [7:0]  HDR_MNP  = 8'hA2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAX_BITS-1:0] i_mPx,
    input  logic [MAX_BITS-1:0] i_mPy,
    input  logic [MAX_BITS-1:0] i_mnPx,
    input  logic [MAX_BITS-1:0] i_mnPy,
    input  logic                i_mP_valid,
    input  logic                i_mnP_valid,
    output logic [7:0]          o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_busy
);

    localparam int SHW    = 2 * MAX_BITS;
    localparam int NBYTES = SHW / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, HDR, XMIT} state_t;

    state_t          state, state_nxt;
    logic            prev_mp, prev_mnp, armed;
    logic            pend_mp, pend_mnp;
    logic [SHW-1:0]  shreg;
    logic [7:0]      hdr;
    logic [CW-1:0]   cnt;
    logic            rise_mp, rise_mnp, want_mp, want_mnp;
    logic            start_mp, start_mnp, at_last;

    // armed blocks a false rise on the first cycle after reset when a valid is already high
    assign rise_mp  = armed & i_mP_valid  & ~prev_mp;
    assign rise_mnp = armed & i_mnP_valid & ~prev_mnp;
    assign want_mp  = rise_mp  | (pend_mp  & i_mP_valid);
    assign want_mnp = rise_mnp | (pend_mnp & i_mnP_valid);
    assign at_last  = (cnt == LAST_CNT);
    assign o_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_mp  = 1'b0;
        start_mnp = 1'b0;
        o_valid   = 1'b0;
        o_last    = 1'b0;
        o_data    = 8'h00;
        case (state)
            IDLE: begin
                if (want_mp) begin
                    start_mp  = 1'b1;
                    state_nxt = HDR;
                end else if (want_mnp) begin
                    start_mnp = 1'b1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                o_valid = 1'b1;
                o_data  = hdr;
                if (i_ready) state_nxt = XMIT;
            end
            XMIT: begin
                o_valid = 1'b1;
                o_data  = shreg[SHW-1 -: 8];
                o_last  = at_last;
                if (i_ready && at_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_mp  <= 1'b0;
            prev_mnp <= 1'b0;
            armed    <= 1'b0;
            pend_mp  <= 1'b0;
            pend_mnp <= 1'b0;
            shreg    <= '0;
            hdr      <= 8'h00;
            cnt      <= '0;
        end else begin
            prev_mp  <= i_mP_valid;
            prev_mnp <= i_mnP_valid;
            armed    <= 1'b1;

            // a pending frame is dropped if the core withdraws the result before it starts
            if (start_mp)        pend_mp <= 1'b0;
            else if (rise_mp)    pend_mp <= 1'b1;
            else if (!i_mP_valid) pend_mp <= 1'b0;

            if (start_mnp)        pend_mnp <= 1'b0;
            else if (rise_mnp)    pend_mnp <= 1'b1;
            else if (!i_mnP_valid) pend_mnp <= 1'b0;

            if (start_mp) begin
                shreg <= {i_mPx, i_mPy};
                hdr   <= HDR_MP;
            end else if (start_mnp) begin
                shreg <= {i_mnPx, i_mnPy};
                hdr   <= HDR_MNP;
            end else if (state == XMIT && i_ready) begin
                shreg <= shreg << 8;
            end

            if (state == HDR && i_ready) begin
                cnt <= '0;
            end else if (state == XMIT && i_ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_result_tx.sv
// Bench for ecc_result_tx at MAX_BITS=16: literal frame table, corner-case sequences,
// and a randomized run checked cycle by cycle against a frame-queue reference model.
module tb_ecc_result_tx;

    localparam int MB = 16;
    localparam int NB = 2 * MB / 8;
    localparam int FL = NB + 1;

    logic          clk, rst;
    logic [MB-1:0] i_mPx, i_mPy, i_mnPx, i_mnPy;
    logic          i_mP_valid, i_mnP_valid;
    logic [7:0]    o_data;
    logic          o_valid, i_ready, o_last, o_busy;

    ecc_result_tx #(.MAX_BITS(MB), .HDR_MP(8'hA1), .HDR_MNP(8'hA2)) dut (
        .clk(clk), .rst(rst),
        .i_mPx(i_mPx), .i_mPy(i_mPy), .i_mnPx(i_mnPx), .i_mnPy(i_mnPy),
        .i_mP_valid(i_mP_valid), .i_mnP_valid(i_mnP_valid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_last(o_last), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: bytes still owed in the current frame, owed frames, expected byte queue
    int         m_rem = 0;
    bit         m_owe_mp, m_owe_mnp, m_prev_mp, m_prev_mnp, m_first;
    logic [7:0] exp_q[$];
    logic [8:0] got_q[$];

    function automatic void push_frame(input logic [7:0] h, input logic [MB-1:0] x, input logic [MB-1:0] y);
        exp_q.push_back(h);
        for (int i = MB/8 - 1; i >= 0; i--) exp_q.push_back(8'((x >> (8*i)) & 'hFF));
        for (int i = MB/8 - 1; i >= 0; i--) exp_q.push_back(8'((y >> (8*i)) & 'hFF));
    endfunction

    always @(negedge clk) begin
        bit was_idle, r_mp, r_mnp;
        if (!rst) begin
            chk("valid_in_reset", o_valid, 0);
            m_rem = 0; m_owe_mp = 0; m_owe_mnp = 0;
            m_prev_mp = 0; m_prev_mnp = 0; m_first = 1;
            exp_q.delete();
        end else begin
            if (o_valid && i_ready) got_q.push_back({o_last, o_data});
            chk("o_valid", o_valid, m_rem > 0);
            chk("o_busy", o_busy, m_rem > 0);
            was_idle = (m_rem == 0);
            if (m_rem > 0) begin
                chk("o_data", o_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
                chk("o_last", o_last, m_rem == 1);
                if (i_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_rem--;
                end
            end
            r_mp  = !m_first && i_mP_valid  && !m_prev_mp;
            r_mnp = !m_first && i_mnP_valid && !m_prev_mnp;
            if (!i_mP_valid)  m_owe_mp  = 0;
            if (!i_mnP_valid) m_owe_mnp = 0;
            if (r_mp)  m_owe_mp  = 1;
            if (r_mnp) m_owe_mnp = 1;
            if (was_idle) begin
                if (m_owe_mp) begin
                    push_frame(8'hA1, i_mPx, i_mPy);
                    m_rem = FL; m_owe_mp = 0;
                end else if (m_owe_mnp) begin
                    push_frame(8'hA2, i_mnPx, i_mnPy);
                    m_rem = FL; m_owe_mnp = 0;
                end
            end
            m_prev_mp  = i_mP_valid;
            m_prev_mnp = i_mnP_valid;
            m_first    = 0;
        end
    end

    bit         rand_rdy = 0;
    logic [3:0] rdy_pat  = 4'hF;
    int         ph       = 0;

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            i_ready = rand_rdy ? ($urandom_range(3) != 0) : rdy_pat[ph % 4];
            ph++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_timeout"}, got_q.size() >= n, 1);
    endtask

    task automatic cmp_frame(input string name, input int off, input logic [39:0] exp);
        for (int i = 0; i < FL; i++) begin
            if (got_q.size() > off + i) begin
                chk({name, "_byte"}, got_q[off+i][7:0], exp[8*(FL-1-i) +: 8]);
                chk({name, "_last"}, got_q[off+i][8], i == FL - 1);
            end else begin
                chk({name, "_missing"}, 0, 1);
            end
        end
    endtask

    typedef struct {
        bit          mnp;
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  pat;
        logic [39:0] exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        tbl[0] = '{0, 16'h1234, 16'hABCD, 4'b1111, 40'hA1_12_34_AB_CD};
        tbl[1] = '{0, 16'h1234, 16'hABCD, 4'b1001, 40'hA1_12_34_AB_CD};
        tbl[2] = '{1, 16'h0102, 16'h0304, 4'b1111, 40'hA2_01_02_03_04};
        tbl[3] = '{0, 16'hFFFF, 16'h0000, 4'b0110, 40'hA1_FF_FF_00_00};

        rst = 1'b0;
        i_mPx = '0; i_mPy = '0; i_mnPx = '0; i_mnPy = '0;
        i_mP_valid = 1'b0; i_mnP_valid = 1'b0;
        #1;
        chk("rst_o_data", o_data, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_o_busy", o_busy, 0);
        tick(3);
        rst = 1'b1;
        tick(2);

        for (int r = 0; r < 4; r++) begin
            got_q.delete();
            rdy_pat = tbl[r].pat;
            ph = 0;
            if (tbl[r].mnp) begin
                i_mnPx = tbl[r].x; i_mnPy = tbl[r].y; i_mnP_valid = 1'b1;
            end else begin
                i_mPx = tbl[r].x; i_mPy = tbl[r].y; i_mP_valid = 1'b1;
            end
            wait_got(FL, 60, "tbl_frame");
            tick(8);
            chk("tbl_count", got_q.size(), FL);
            cmp_frame("tbl", 0, tbl[r].exp);
            i_mP_valid = 1'b0; i_mnP_valid = 1'b0;
            tick(3);
        end
        rdy_pat = 4'hF;

        // simultaneous rise: mP first, mnP right after
        got_q.delete();
        i_mPx = 16'h1234; i_mPy = 16'hABCD; i_mnPx = 16'h0102; i_mnPy = 16'h0304;
        i_mP_valid = 1'b1; i_mnP_valid = 1'b1;
        wait_got(2*FL, 80, "simul");
        tick(5);
        chk("simul_count", got_q.size(), 2*FL);
        cmp_frame("simul_mp", 0, 40'hA1_12_34_AB_CD);
        cmp_frame("simul_mnp", FL, 40'hA2_01_02_03_04);
        i_mP_valid = 1'b0; i_mnP_valid = 1'b0;
        tick(3);

        // mnP pulse withdrawn during the mP frame: dropped
        got_q.delete();
        i_mP_valid = 1'b1;
        tick(2);
        i_mnP_valid = 1'b1;
        tick(1);
        i_mnP_valid = 1'b0;
        wait_got(FL, 40, "drop");
        tick(10);
        chk("drop_count", got_q.size(), FL);
        i_mP_valid = 1'b0;
        tick(3);

        // mnP rises mid-frame and stays: sent after mP
        got_q.delete();
        i_mP_valid = 1'b1;
        tick(2);
        i_mnP_valid = 1'b1;
        wait_got(2*FL, 80, "midrise");
        tick(5);
        chk("midrise_count", got_q.size(), 2*FL);
        cmp_frame("midrise_mp", 0, 40'hA1_12_34_AB_CD);
        cmp_frame("midrise_mnp", FL, 40'hA2_01_02_03_04);
        i_mP_valid = 1'b0; i_mnP_valid = 1'b0;
        tick(3);

        // reset after two bytes; held-high valid must not retrigger
        got_q.delete();
        i_mP_valid = 1'b1;
        wait_got(2, 30, "rstmid");
        rst = 1'b0;
        #1;
        chk("rstmid_o_valid", o_valid, 0);
        chk("rstmid_o_busy", o_busy, 0);
        tick(2);
        rst = 1'b1;
        tick(15);
        chk("rstmid_no_retrig", got_q.size(), 2);
        i_mP_valid = 1'b0;
        tick(2);
        i_mP_valid = 1'b1;
        wait_got(2 + FL, 40, "rstmid_new");
        cmp_frame("rstmid_new", 2, 40'hA1_12_34_AB_CD);
        i_mP_valid = 1'b0;
        tick(3);

        // inputs changed after frame start do not leak into the frame
        got_q.delete();
        i_mPx = 16'h1234; i_mPy = 16'hABCD;
        i_mP_valid = 1'b1;
        tick(1);
        i_mPx = 16'hDEAD; i_mPy = 16'hBEEF;
        wait_got(FL, 40, "capture");
        cmp_frame("capture", 0, 40'hA1_12_34_AB_CD);
        i_mP_valid = 1'b0;
        tick(3);

        rand_rdy = 1;
        for (int c = 0; c < 3000; c++) begin
            i_mPx  = MB'($urandom); i_mPy  = MB'($urandom);
            i_mnPx = MB'($urandom); i_mnPy = MB'($urandom);
            if ($urandom_range(29) == 0) i_mP_valid  = ~i_mP_valid;
            if ($urandom_range(29) == 0) i_mnP_valid = ~i_mnP_valid;
            tick();
        end
        i_mP_valid = 1'b0; i_mnP_valid = 1'b0;
        rand_rdy = 0;
        rdy_pat = 4'hF;
        tick(3 * FL);
        chk("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
